// File: rtl/updn_counter_mod.sv
// Up/down modulo counter with variable step, wrap or saturate overflow, and one-cycle event pulses.
// Optional embedded checks are compiled in when UPDN_CNT_ASSERT_EN is defined.
module updn_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1,
    parameter int STEP_W  = WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              ce,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              wrap_evt,
    output logic              sat_evt
);

    localparam int             MW    = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;
    localparam logic [WIDTH:0] MOD   = (WIDTH + 1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max_val
        $error("updn_counter_mod: MAX_VAL out of range 1..2**WIDTH-1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             wrap;
        logic             sat;
    } step_res_t;

    step_res_t        step_res;
    logic [WIDTH-1:0] s_eff;

    function automatic logic [WIDTH-1:0] eff_step(input logic [STEP_W-1:0] st);
        logic [MW-1:0] wide;
        wide = MW'(st) % MW'(MOD);
        return wide[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
        return (d > MAX_V) ? MAX_V : d;
    endfunction

    function automatic step_res_t count_up(input logic [WIDTH-1:0] c,
                                           input logic [WIDTH-1:0] s,
                                           input logic             sm);
        step_res_t      r;
        logic [WIDTH:0] sum;
        logic [WIDTH:0] wrapped;
        sum     = {1'b0, c} + {1'b0, s};
        wrapped = sum - MOD;
        r       = '0;
        if (sum <= {1'b0, MAX_V}) begin
            r.cnt = sum[WIDTH-1:0];
        end else if (sm) begin
            r.cnt = MAX_V;
            r.sat = 1'b1;
        end else begin
            r.cnt  = wrapped[WIDTH-1:0];
            r.wrap = 1'b1;
        end
        return r;
    endfunction

    function automatic step_res_t count_down(input logic [WIDTH-1:0] c,
                                             input logic [WIDTH-1:0] s,
                                             input logic             sm);
        step_res_t      r;
        logic [WIDTH:0] wrapped;
        // c + MOD - s stays within WIDTH+1 bits because c <= MAX_VAL and MOD <= 2**WIDTH
        wrapped = {1'b0, c} + MOD - {1'b0, s};
        r       = '0;
        if (s <= c) begin
            r.cnt = c - s;
        end else if (sm) begin
            r.cnt = '0;
            r.sat = 1'b1;
        end else begin
            r.cnt  = wrapped[WIDTH-1:0];
            r.wrap = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        s_eff    = eff_step(step);
        step_res = up_down ? count_up(count_out, s_eff, sat_mode)
                           : count_down(count_out, s_eff, sat_mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
            wrap_evt  <= 1'b0;
            sat_evt   <= 1'b0;
        end else if (!load_n) begin
            count_out <= clamp_load(data_load);
            wrap_evt  <= 1'b0;
            sat_evt   <= 1'b0;
        end else if (ce) begin
            count_out <= step_res.cnt;
            wrap_evt  <= step_res.wrap;
            sat_evt   <= step_res.sat;
        end else begin
            wrap_evt  <= 1'b0;
            sat_evt   <= 1'b0;
        end
    end

    assign max_count = (count_out == MAX_V);
    assign zero      = (count_out == '0);

`ifdef UPDN_CNT_ASSERT_EN
    // Checks only arm after a reset edge so that $past never looks at unreset state.
    logic seen_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_rst <= 1'b1;
        end
    end

    function automatic logic [WIDTH+1:0] ref_next(input longint c, input longint st,
                                                  input logic up, input logic sm);
        longint s;
        longint n;
        logic   w;
        logic   t;
        s = st % (longint'(MAX_VAL) + 1);
        w = 1'b0;
        t = 1'b0;
        if (up) begin
            n = c + s;
            if (n > MAX_VAL) begin
                if (sm) begin n = MAX_VAL; t = 1'b1; end
                else    begin n = n - (MAX_VAL + 1); w = 1'b1; end
            end
        end else begin
            n = c - s;
            if (n < 0) begin
                if (sm) begin n = 0; t = 1'b1; end
                else    begin n = n + (MAX_VAL + 1); w = 1'b1; end
            end
        end
        return {WIDTH'(n), w, t};
    endfunction

    a_range: assert property (@(posedge clk) disable iff (rst)
        seen_rst |-> count_out <= MAX_V)
        else $error("a_range failed");

    a_load: assert property (@(posedge clk) disable iff (rst)
        seen_rst && !$past(rst) && !$past(load_n)
        |-> count_out == (($past(data_load) > MAX_V) ? MAX_V : $past(data_load))
            && !wrap_evt && !sat_evt)
        else $error("a_load failed");

    a_hold: assert property (@(posedge clk) disable iff (rst)
        seen_rst && !$past(rst) && $past(load_n) && !$past(ce)
        |-> count_out == $past(count_out) && !wrap_evt && !sat_evt)
        else $error("a_hold failed");

    a_count: assert property (@(posedge clk) disable iff (rst)
        seen_rst && !$past(rst) && $past(load_n) && $past(ce)
        |-> {count_out, wrap_evt, sat_evt} ==
            ref_next(longint'($past(count_out)), longint'($past(step)),
                     $past(up_down), $past(sat_mode)))
        else $error("a_count failed");

    a_evt_excl: assert property (@(posedge clk) disable iff (rst)
        !(wrap_evt && sat_evt))
        else $error("a_evt_excl failed");

    a_flags: assert property (@(posedge clk) disable iff (rst)
        seen_rst |-> (max_count == (count_out == MAX_V)) && (zero == (count_out == '0)))
        else $error("a_flags failed");

    a_reset: assert property (@(posedge clk) disable iff (rst)
        $past(rst) |-> count_out == '0 && !wrap_evt && !sat_evt)
        else $error("a_reset failed");
`endif

endmodule

// File: tb/tb_updn_counter_mod.sv
// Directed-vector bench for updn_counter_mod (WIDTH=4, MAX_VAL=9) with a queue-based scoreboard.
module tb_updn_counter_mod;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;
    localparam int STEP_W  = 4;

    logic              clk;
    logic              rst;
    logic              load_n;
    logic [WIDTH-1:0]  data_load;
    logic              ce;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic [WIDTH-1:0]  count_out;
    logic              max_count;
    logic              zero;
    logic              wrap_evt;
    logic              sat_evt;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] cnt;
        logic             mx;
        logic             zr;
        logic             wr;
        logic             st;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    updn_counter_mod #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_n    (load_n),
        .data_load (data_load),
        .ce        (ce),
        .up_down   (up_down),
        .step      (step),
        .sat_mode  (sat_mode),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero),
        .wrap_evt  (wrap_evt),
        .sat_evt   (sat_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs and queue the hand-computed result for that edge.
    task automatic vec(input string nm, input logic r, input logic ln, input logic [3:0] dl,
                       input logic c, input logic u, input logic [3:0] st, input logic sm,
                       input logic [3:0] ec, input logic ew, input logic es);
        exp_t e;
        @(negedge clk);
        rst       = r;
        load_n    = ln;
        data_load = dl;
        ce        = c;
        up_down   = u;
        step      = st;
        sat_mode  = sm;
        e.name = nm;
        e.cnt  = ec;
        e.mx   = (ec == 4'd9);
        e.zr   = (ec == 4'd0);
        e.wr   = ew;
        e.st   = es;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (count_out !== e.cnt || max_count !== e.mx || zero !== e.zr ||
                    wrap_evt !== e.wr || sat_evt !== e.st) begin
                    n_err++;
                    $display("FAIL %s: got cnt=%0d max=%b zero=%b wrap=%b sat=%b, want cnt=%0d max=%b zero=%b wrap=%b sat=%b",
                             e.name, count_out, max_count, zero, wrap_evt, sat_evt,
                             e.cnt, e.mx, e.zr, e.wr, e.st);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        load_n    = 1'b1;
        data_load = '0;
        ce        = 1'b0;
        up_down   = 1'b1;
        step      = '0;
        sat_mode  = 1'b0;

        //    name            rst ln  dl    ce u  step  sm  cnt   wr st
        vec("reset_1",        1, 1, 4'd0,  0, 1, 4'd0, 0, 4'd0, 0, 0);
        vec("reset_2",        1, 1, 4'd0,  0, 1, 4'd0, 0, 4'd0, 0, 0);
        vec("idle_after_rst", 0, 1, 4'd0,  0, 1, 4'd0, 0, 4'd0, 0, 0);
        vec("load_7",         0, 0, 4'd7,  0, 1, 4'd0, 0, 4'd7, 0, 0);
        vec("load_14_clamp",  0, 0, 4'd14, 0, 1, 4'd0, 0, 4'd9, 0, 0);
        vec("load_8",         0, 0, 4'd8,  0, 1, 4'd0, 0, 4'd8, 0, 0);
        vec("up_wrap",        0, 1, 4'd0,  1, 1, 4'd3, 0, 4'd1, 1, 0);
        vec("wrap_clears",    0, 1, 4'd0,  0, 1, 4'd3, 0, 4'd1, 0, 0);
        vec("load_8b",        0, 0, 4'd8,  0, 1, 4'd0, 0, 4'd8, 0, 0);
        vec("up_sat",         0, 1, 4'd0,  1, 1, 4'd3, 1, 4'd9, 0, 1);
        vec("up_sat_at_max",  0, 1, 4'd0,  1, 1, 4'd3, 1, 4'd9, 0, 1);
        vec("load_1",         0, 0, 4'd1,  0, 1, 4'd0, 0, 4'd1, 0, 0);
        vec("down_wrap",      0, 1, 4'd0,  1, 0, 4'd2, 0, 4'd9, 1, 0);
        vec("load_1b",        0, 0, 4'd1,  0, 0, 4'd0, 0, 4'd1, 0, 0);
        vec("down_sat",       0, 1, 4'd0,  1, 0, 4'd2, 1, 4'd0, 0, 1);
        vec("down_sat_at_0",  0, 1, 4'd0,  1, 0, 4'd1, 1, 4'd0, 0, 1);
        vec("step_0",         0, 1, 4'd0,  1, 1, 4'd0, 0, 4'd0, 0, 0);
        vec("step_10_is_0",   0, 1, 4'd0,  1, 1, 4'd10,1, 4'd0, 0, 0);
        vec("load_5",         0, 0, 4'd5,  0, 1, 4'd0, 0, 4'd5, 0, 0);
        vec("load_beats_ce",  0, 0, 4'd2,  1, 1, 4'd1, 0, 4'd2, 0, 0);
        vec("hold_1",         0, 1, 4'd0,  0, 1, 4'd1, 0, 4'd2, 0, 0);
        vec("hold_2",         0, 1, 4'd0,  0, 0, 4'd3, 1, 4'd2, 0, 0);
        vec("hold_3",         0, 1, 4'd0,  0, 1, 4'd7, 0, 4'd2, 0, 0);
        vec("load_4",         0, 0, 4'd4,  0, 1, 4'd0, 0, 4'd4, 0, 0);
        vec("up_step12",      0, 1, 4'd0,  1, 1, 4'd12,0, 4'd6, 0, 0);
        vec("rst_beats_load", 1, 0, 4'd5,  1, 1, 4'd12,0, 4'd0, 0, 0);
        vec("hold_after_rst", 0, 1, 4'd0,  0, 1, 4'd0, 0, 4'd0, 0, 0);
        vec("load_9",         0, 0, 4'd9,  0, 1, 4'd0, 0, 4'd9, 0, 0);
        vec("down_plain",     0, 1, 4'd0,  1, 0, 4'd4, 0, 4'd5, 0, 0);
        vec("up_to_max",      0, 1, 4'd0,  1, 1, 4'd4, 0, 4'd9, 0, 0);
        vec("up_step15_wrap", 0, 1, 4'd0,  1, 1, 4'd15,0, 4'd4, 1, 0);
        vec("final_hold",     0, 1, 4'd0,  0, 1, 4'd0, 0, 4'd4, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/updn_counter_mod.md
# updn_counter_mod

Parametrised up/down modulo counter with configurable upper bound, variable step, and selectable wrap or saturate overflow handling. It extends the basic load/enable/up-down counter with:
- arbitrary modulus (MAX_VAL+1);
- per-cycle step size;
- registered one-cycle wrap and saturate event pulses.

It is the counter primitive for timers and index generators across the design. It can optionally carry its own embedded assertion checks.

## Interface
- WIDTH, 8, counter width in bits.
- MAX_VAL, 2**WIDTH-1, largest legal count; range is 0..MAX_VAL. Legal: 1 ≤ MAX_VAL ≤ 2**WIDTH-1. Any other value is an elaboration error.
- STEP_W, WIDTH, width of the step input.

- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- load_n  input  1  active-low synchronous load.
- data_load  input  WIDTH  load value.
- ce  input  1  count enable.
- up_down  input  1  1 = count up, 0 = count down.
- step  input  STEP_W  increment/decrement amount per enabled cycle.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1.
- count_out  output  WIDTH  current count, registered.
- max_count  output  1  combinational: count_out == MAX_VAL.
- zero  output  1  combinational: count_out == 0.
- wrap_evt  output  1  registered pulse: last update wrapped.
- sat_evt  output  1  registered pulse: last update was clamped.

## Operation
- Priority per edge: rst > load (load_n=0) > count (ce=1) > hold.

Reset:
- count_out=0, wrap_evt=0, sat_evt=0.
- Therefore zero=1 and max_count=0.

Load:
- count_out = min(data_load, MAX_VAL).
- wrap_evt=0, sat_evt=0.

Hold (load_n=1, ce=0):
- count_out unchanged; both events 0.

Step handling:
- Effective step s = step mod (MAX_VAL+1).
- s=0: count unchanged, no events.

Count up:
- Compute sum = count_out + s in WIDTH+1 bits.
- sum ≤ MAX_VAL: count_out=sum.
- Otherwise, sat_mode=1: count_out=MAX_VAL, sat_evt=1.
- Otherwise, sat_mode=0: count_out = sum − (MAX_VAL+1), wrap_evt=1.

Count down:
- s ≤ count_out: count_out = count_out − s.
- Otherwise, sat_mode=1: count_out=0, sat_evt=1.
- Otherwise, sat_mode=0: count_out = count_out + (MAX_VAL+1) − s, wrap_evt=1.

Invariants and event rules:
- count_out never exceeds MAX_VAL.
- wrap_evt and sat_evt are never both 1.
- An event is 1 only in the cycle after the edge that produced it. It clears on the next edge unless re-triggered.
- Counting already at a bound in saturate mode with s>0 (up at MAX_VAL, down at 0) re-asserts sat_evt; the count stays at the bound.

## Timing
- Load and count latency: 1 cycle (input sampled at edge N, count_out valid after edge N).
- max_count and zero follow count_out combinationally, with no extra latency.
- wrap_evt and sat_evt are aligned with the count_out value they describe.
- rst asserted mid-count, or together with load_n=0/ce=1: reset wins; outputs take reset values after that edge.
- load_n=0 with ce=1: load wins; step and up_down are ignored.
- sat_mode, up_down and step may change every cycle; only values sampled at the edge matter.

## Configuration
- UPDN_CNT_ASSERT_EN defined: embedded concurrent assertions are compiled in. They are clocked on clk and disabled during rst, and check:
  - count_out ≤ MAX_VAL;
  - load result matches min($past(data_load), MAX_VAL);
  - hold keeps the previous value;
  - up/down result matches the wrap/saturate rules above;
  - wrap_evt and sat_evt are mutually exclusive;
  - max_count and zero are consistent with count_out;
  - count_out==0 after a reset edge.

  Each failure prints its assertion name.
- UPDN_CNT_ASSERT_EN not defined: no assertion code. Ports and functional behaviour are identical.

## Test plan
Configuration: WIDTH=4, MAX_VAL=9, UPDN_CNT_ASSERT_EN defined.
- Reset: rst=1 for 2 cycles, then 0, with ce=0 → count_out=0, zero=1, max_count=0, both events 0.
- Load with clamp: load_n=0, data_load=7 → count_out=7. Then data_load=14 → count_out=9, max_count=1.
- Up overflow: from 8, ce=1, up_down=1, step=3.
  - sat_mode=0 → count_out=1, wrap_evt=1 for one cycle.
  - Repeat from 8 with sat_mode=1 → count_out=9, sat_evt=1.
- Down underflow: from 1, up_down=0, step=2.
  - sat_mode=0 → count_out=9, wrap_evt=1.
  - sat_mode=1 → count_out=0, zero=1, sat_evt=1.
- Priority: count=5, load_n=0, ce=1, up_down=1, step=1, data_load=2 → count_out=2, no events. Then load_n=1, ce=0 for 3 cycles → stays 2.
- Reset mid-operation: counting up with step=12 (effective step 2) from 4 → 6. Then rst=1 together with load_n=0, data_load=5 → count_out=0, events 0, zero=1.
